// File: rtl/key_led_indicator.sv
// Turns single-cycle key events into timed LED blinks, queueing events that arrive mid-blink.
// Optional macro KEY_LED_DOUBLE_BLINK_EN: each event produces two blinks instead of one.
module key_led_indicator #(
  parameter logic [23:0] ON_MAX      = 24'd12_499_999,
  parameter logic [23:0] OFF_MAX     = 24'd12_499_999,
  parameter logic [3:0]  PEND_MAX    = 4'd15,
  parameter logic        LED_ACT_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       evt_in,
  output logic       led_out,
  output logic       busy,
  output logic [3:0] pend_cnt,
  output logic       ovf
);

  localparam int unsigned TMR_W = 24;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  state_t           state;
  logic [TMR_W-1:0] timer;
`ifdef KEY_LED_DOUBLE_BLINK_EN
  logic             blink_idx;
`endif

  logic start_c;
  logic dec_c;
  logic queue_in_c;

  // An event that starts a blink from an empty queue bypasses the counter.
  always_comb begin
    start_c    = 1'b0;
    dec_c      = 1'b0;
    queue_in_c = 1'b0;
    if (state == IDLE) begin
      start_c = evt_in | (pend_cnt != '0);
    end
    dec_c      = start_c & (pend_cnt != '0);
    queue_in_c = evt_in & ~(start_c & (pend_cnt == '0));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      timer    <= '0;
      pend_cnt <= '0;
      ovf      <= 1'b0;
      led_out  <= LED_ACT_LOW;
      busy     <= 1'b0;
`ifdef KEY_LED_DOUBLE_BLINK_EN
      blink_idx <= 1'b0;
`endif
    end else begin
      ovf <= 1'b0;

      // Pending-event queue with saturation and drop reporting.
      if (queue_in_c && !dec_c) begin
        if (pend_cnt == PEND_MAX) begin
          ovf <= 1'b1;
        end else begin
          pend_cnt <= pend_cnt + CNT_W'(1);
        end
      end else if (!queue_in_c && dec_c) begin
        pend_cnt <= pend_cnt - CNT_W'(1);
      end

      case (state)
        IDLE: begin
          if (start_c) begin
            state   <= ON;
            timer   <= '0;
            led_out <= ~LED_ACT_LOW;
            busy    <= 1'b1;
`ifdef KEY_LED_DOUBLE_BLINK_EN
            blink_idx <= 1'b0;
`endif
          end
        end
        ON: begin
          if (timer == ON_MAX) begin
            state   <= OFF;
            timer   <= '0;
            led_out <= LED_ACT_LOW;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        OFF: begin
          if (timer == OFF_MAX) begin
            timer <= '0;
`ifdef KEY_LED_DOUBLE_BLINK_EN
            if (!blink_idx) begin
              state     <= ON;
              blink_idx <= 1'b1;
              led_out   <= ~LED_ACT_LOW;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
`else
            state <= IDLE;
            busy  <= 1'b0;
`endif
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          timer   <= '0;
          led_out <= LED_ACT_LOW;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_led_indicator.sv
// Directed bench for key_led_indicator with ON_MAX=3, OFF_MAX=2, PEND_MAX=3, active-low LED.
module tb_key_led_indicator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       evt_in = 1'b0;
  logic       led_out;
  logic       busy;
  logic [3:0] pend_cnt;
  logic       ovf;

  key_led_indicator #(
    .ON_MAX     (24'd3),
    .OFF_MAX    (24'd2),
    .PEND_MAX   (4'd3),
    .LED_ACT_LOW(1'b1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .evt_in  (evt_in),
    .led_out (led_out),
    .busy    (busy),
    .pend_cnt(pend_cnt),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  string       scn;
  logic [63:0] evt_m;
  logic [63:0] lit_m;
  logic [63:0] busy_m;
  logic [63:0] ovf_m;
  logic [3:0]  pend_e [64];
  int          rst_cyc;

  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic set_pend(input int lo, input int hi, input logic [3:0] v);
    for (int i = lo; i <= hi; i++) pend_e[i] = v;
  endtask

  task automatic new_scn(input string name);
    scn     = name;
    evt_m   = '0;
    lit_m   = '0;
    busy_m  = '0;
    ovf_m   = '0;
    rst_cyc = -1;
    for (int i = 0; i < 64; i++) pend_e[i] = 4'd0;
  endtask

  task automatic chk(input string tag, input int cyc, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s/%s cycle %0d: observed %0d expected %0d", scn, tag, cyc, obs, exp);
    end
  endtask

  // Reset for 5 edges with evt_in toggling, then cycles 1..ncyc checked against the tables.
  task automatic run(input int ncyc);
    @(negedge clk);
    rst_n  = 1'b0;
    evt_in = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_led", -k, {3'b0, led_out}, 4'd1);
      chk("rst_busy", -k, {3'b0, busy}, 4'd0);
      chk("rst_pend", -k, pend_cnt, 4'd0);
      chk("rst_ovf", -k, {3'b0, ovf}, 4'd0);
      evt_in = ~evt_in;
    end
    for (int n = 1; n <= ncyc; n++) begin
      if (n > 1) begin
        @(negedge clk);
        chk("led", n, {3'b0, led_out}, {3'b0, ~lit_m[n]});
        chk("busy", n, {3'b0, busy}, {3'b0, busy_m[n]});
        chk("pend", n, pend_cnt, pend_e[n]);
        chk("ovf", n, {3'b0, ovf}, {3'b0, ovf_m[n]});
      end
      rst_n  = (n != rst_cyc);
      evt_in = evt_m[n];
      @(posedge clk);
    end
    @(negedge clk);
    evt_in = 1'b0;
  endtask

  initial begin
    new_scn("single");
    evt_m  = rng(10, 10);
    lit_m  = rng(11, 14);
    busy_m = rng(11, 17);
    run(30);

    new_scn("burst");
    evt_m  = rng(10, 12);
    lit_m  = rng(11, 14) | rng(19, 22) | rng(27, 30);
    busy_m = rng(11, 17) | rng(19, 25) | rng(27, 33);
    set_pend(12, 12, 4'd1);
    set_pend(13, 18, 4'd2);
    set_pend(19, 26, 4'd1);
    run(40);

    new_scn("overflow");
    evt_m  = rng(10, 10) | rng(12, 16);
    lit_m  = rng(11, 14) | rng(19, 22) | rng(27, 30) | rng(35, 38);
    busy_m = rng(11, 17) | rng(19, 25) | rng(27, 33) | rng(35, 41);
    ovf_m  = rng(16, 17);
    set_pend(13, 13, 4'd1);
    set_pend(14, 14, 4'd2);
    set_pend(15, 18, 4'd3);
    set_pend(19, 26, 4'd2);
    set_pend(27, 34, 4'd1);
    run(50);

    new_scn("simul");
    evt_m  = rng(10, 10) | rng(18, 18);
    lit_m  = rng(11, 14) | rng(19, 22);
    busy_m = rng(11, 17) | rng(19, 25);
    run(32);

    new_scn("simul_queued");
    evt_m  = rng(10, 11) | rng(18, 18);
    lit_m  = rng(11, 14) | rng(19, 22) | rng(27, 30);
    busy_m = rng(11, 17) | rng(19, 25) | rng(27, 33);
    set_pend(12, 26, 4'd1);
    run(40);

    new_scn("rst_mid");
    evt_m   = rng(10, 11);
    rst_cyc = 13;
    lit_m   = rng(11, 13);
    busy_m  = rng(11, 13);
    set_pend(12, 13, 4'd1);
    run(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/key_led_indicator.md
Name: key_led_indicator

Overview:
- Output-side counterpart of the key debounce path: consumes single-cycle key event pulses and drives a physical LED pin with one timed blink per event.
- Events arriving while a blink is in progress are queued in a saturating pending counter and replayed in order.
- Sits between the debounced key flags (or any 1-cycle event strobe) and the board LED pin; runs in the 50 MHz system clock domain.

Parameters:
- ON_MAX, 24'd12_499_999, LED-on time minus 1 in clk cycles (250 ms at 50 MHz); ON lasts ON_MAX+1 cycles.
- OFF_MAX, 24'd12_499_999, mandatory dark gap minus 1 after each blink; OFF lasts OFF_MAX+1 cycles.
- PEND_MAX, 4'd15, saturation value of the pending-event counter (1..15).
- LED_ACT_LOW, 1'b1, 1 = LED pin driven low when lit; 0 = driven high when lit.

Ports:
- clk  input  1  system clock, 50 MHz
- rst_n  input  1  synchronous, active-low reset
- evt_in  input  1  event strobe, 1 cycle high per event; back-to-back pulses are separate events
- led_out  output  1  LED pin; polarity per LED_ACT_LOW
- busy  output  1  high whenever state != IDLE
- pend_cnt  output  4  events queued and not yet started
- ovf  output  1  1-cycle pulse: an event was dropped because the queue was full

Behaviour:
- All outputs registered. Reset (rst_n low at posedge clk): state IDLE, timer 0, pend_cnt 0, ovf 0, led_out inactive (1 if LED_ACT_LOW else 0), busy 0. Reset mid-blink aborts: inactive from the next cycle, queue flushed.
- FSM states IDLE, ON, OFF. 24-bit timer, cleared on every state entry.
- IDLE: start = evt_in | (pend_cnt != 0). If start, go to ON next cycle. Otherwise stay.
- ON: LED lit. Timer increments each cycle. When timer == ON_MAX, go to OFF and clear the timer.
- OFF: LED dark. Timer increments. When timer == OFF_MAX, go to IDLE.
- IDLE always lasts at least 1 cycle between blinks.
- Queue accounting each cycle:
  - inc = evt_in; dec = start & (pend_cnt != 0).
  - If start is taken with pend_cnt == 0, the simultaneous evt_in is consumed directly and pend_cnt stays 0.
  - inc & dec: pend_cnt unchanged.
  - inc & !dec & pend_cnt == PEND_MAX: pend_cnt held, ovf = 1 next cycle.
  - Otherwise pend_cnt = pend_cnt + inc - dec.
- Latency: evt_in sampled high in IDLE with empty queue -> LED lit on the following cycle.
- ovf is high for exactly 1 cycle per dropped event. Consecutive drops give consecutive high cycles.
- Timer never exceeds max(ON_MAX, OFF_MAX). No wrap-around is possible.

Optional Feature:
- Macro KEY_LED_DOUBLE_BLINK_EN.
- Defined:
  - Each event produces two blinks: ON, OFF, ON, OFF, then IDLE.
  - Adds a 1-bit blink index: cleared on the IDLE->ON transition, set at the end of the first OFF.
  - At the end of the first OFF, go to ON, not IDLE.
  - Queue is decremented only at event start.
  - busy stays high across both blinks.
- Undefined: single blink per event as above; the blink-index register does not exist.

Test Plan (ON_MAX=3, OFF_MAX=2, PEND_MAX=3, LED_ACT_LOW=1, cycle n = n-th posedge after reset release):
- Reset: hold rst_n low 5 cycles with evt_in toggling -> led_out=1, busy=0, pend_cnt=0, ovf=0 throughout.
- Single event: evt_in high cycle 10 ->
  - led_out=0 cycles 11-14.
  - led_out=1 cycles 15-17 (OFF) and from 18.
  - busy high 11-17, low at 18; pend_cnt stays 0.
- Burst: evt_in high cycles 10, 11, 12 ->
  - pend_cnt=1 at 12, 2 at 13.
  - blinks lit 11-14, 19-22, 27-30.
  - pend_cnt drops to 1 at 19 and to 0 at 27.
  - no ovf.
- Overflow: evt_in at 10, then high 12-16 ->
  - pend_cnt 1/2/3 at 13/14/15, held at 3.
  - ovf high cycles 16 and 17 only.
  - exactly 4 blinks total.
- Simultaneous: evt_in at 10 and at 18 (IDLE restart with pend_cnt=0) ->
  - second blink lit 19-22, pend_cnt stays 0.
  - Repeat with a queued event plus evt_in at the restart cycle -> pend_cnt unchanged that cycle.
- Reset mid-blink: evt_in at 10 and 11, rst_n low at cycle 13 ->
  - led_out=1, busy=0, pend_cnt=0 from cycle 14.
  - no further blinks after rst_n returns high.
